// File: rtl/prog_loader.sv
// Streaming program loader. It parses a framed byte stream
// (SYNC, LEN_LO, LEN_HI, 4*N data bytes, CSUM), writes each assembled
// little-endian 32-bit word into instruction memory, and releases the core
// from reset only once a complete frame with a valid XOR checksum has loaded.
//
// Handshake: in_ready is tied high, so a byte transfers on every rising edge
// where in_valid is 1. When in_valid is 0, all state holds.
module prog_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_n_rst,
  output logic              done,
  output logic [1:0]        err,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH       = 17'(2 ** ADDR_W);
  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_LEN     = 2'b01;
  localparam logic [1:0]  ERR_CSUM    = 2'b10;

  state_t            state, state_n;
  logic [1:0]        err_n;
  logic [15:0]       len;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [23:0]       word_buf;
  logic [7:0]        csum;
  logic [15:0]       len_word;
  logic              last_word;

  assign in_ready  = 1'b1;
  assign fsm_state = state;

  // Full word count as it becomes known on the LEN_HI byte.
  assign len_word  = {in_data, len[7:0]};
  // The current word is the final one of the frame.
  assign last_word = (16'(word_cnt) == (len - 16'd1));

  // Next-state and error-code selection.
  always_comb begin
    state_n = state;
    err_n   = (state == S_ERR) ? err : ERR_NONE;
    if (in_valid) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (in_data == SYNC) begin
            state_n = S_LEN_LO;
            err_n   = ERR_NONE;
          end
        end
        S_LEN_LO: state_n = S_LEN_HI;
        S_LEN_HI: begin
          if ({1'b0, len_word} > DEPTH) begin
            state_n = S_ERR;
            err_n   = ERR_LEN;
          end else if (len_word == 16'd0) begin
            state_n = S_CSUM;
          end else begin
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          if (byte_cnt == 2'd3 && last_word) state_n = S_CSUM;
        end
        S_CSUM: begin
          if (in_data == csum) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ERR;
            err_n   = ERR_CSUM;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      err        <= ERR_NONE;
      done       <= 1'b0;
      core_n_rst <= 1'b0;
    end else begin
      state      <= state_n;
      err        <= err_n;
      done       <= (state_n == S_DONE);
      core_n_rst <= (state_n == S_DONE);
    end
  end

  // Datapath: length capture, word assembly, checksum and memory write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= 16'd0;
      byte_cnt   <= 2'd0;
      word_cnt   <= '0;
      word_buf   <= 24'd0;
      csum       <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (in_valid) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            // A new frame starts: clear the per-frame accumulators.
            if (in_data == SYNC) begin
              csum     <= 8'd0;
              byte_cnt <= 2'd0;
              word_cnt <= '0;
            end
          end
          S_LEN_LO: len[7:0]  <= in_data;
          S_LEN_HI: len[15:8] <= in_data;
          S_DATA: begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt;
                imem_wdata <= {in_data, word_buf};
                word_cnt   <= word_cnt + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
REQ-002 Parameter: SYNC, 8'hA5, frame start byte.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  stream byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of write.
REQ-010 imem_wdata  output  32  word written.
REQ-011 core_n_rst  output  1  active-low reset to core; high only when program loaded.
REQ-012 done  output  1  load completed and checksum valid.
REQ-013 err  output  2  00 none, 01 length overflow, 10 checksum mismatch.

Function
REQ-014 Frame = SYNC, LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N data bytes, CSUM.
REQ-015 Each data word is little-endian: first byte -> [7:0], fourth byte -> [31:24].
REQ-016 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
REQ-017 IDLE: byte == SYNC -> LEN_LO; any other byte is discarded.
REQ-018 LEN_LO -> LEN_HI on accept. LEN_HI: N > DEPTH -> ERR with err=01; N == 0 -> CSUM; otherwise -> DATA.
REQ-019 DATA: bytes are assembled in a byte counter (0..3) and a word counter; after 4th byte of word N-1 -> CSUM.
REQ-020 On acceptance of the 4th byte of word k, the next cycle drives imem_we=1, imem_addr=k, and imem_wdata=the assembled word, all registered; imem_we is 0 all other cycles.
REQ-021 Word addresses start at 0 per frame and increment by 1; they never wrap, since N <= DEPTH.
REQ-022 Checksum is the 8-bit XOR of all data bytes only (excludes SYNC, LEN, CSUM); it is cleared on entry to LEN_LO; N == 0 requires CSUM=8'h00.
REQ-023 CSUM: match -> DONE; mismatch -> ERR with err=10.
REQ-024 in_ready = 1 in every state; back-to-back bytes every cycle are accepted with no loss.
REQ-025 DONE/ERR: SYNC byte -> LEN_LO, clearing done and err and dropping core_n_rst the next cycle; other bytes are discarded.
REQ-026 core_n_rst and done are registered; both are 1 only while in DONE, first asserting the cycle after the CSUM byte is accepted.
REQ-027 err holds its code while in ERR and is 00 in all other states.
REQ-028 No state has a timeout; a stalled stream (in_valid=0) holds all state indefinitely.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, counters=0, checksum=0, imem_we=0, imem_addr=0, imem_wdata=0, core_n_rst=0, done=0, err=00.
REQ-030 rst mid-frame aborts the frame; any words already written remain in memory; no write occurs in the cycle following reset.

Verification
REQ-031 Stream A5 02 00 13 05 A0 00 93 05 50 00 CS (CS=XOR of the 8 data bytes) -> writes addr0=00A00513 and addr1=00500593; core_n_rst and done rise 1 cycle after CS; err=00.
REQ-032 Same frame with CS^8'h01 -> ERR, err=10, core_n_rst stays 0, done=0.
REQ-033 ADDR_W=4, LEN=0x0011 -> ERR, err=01 immediately after LEN_HI; zero imem writes.
REQ-034 Leading bytes 00 FF 13 before A5, then a 1-word frame -> junk ignored; one write at addr0; done=1.
REQ-035 rst asserted after 6 data bytes of a 2-word frame -> one write only (addr0), all outputs at reset values, a subsequent full frame loads correctly.
REQ-036 From DONE, send a new frame with in_valid gapped every other cycle -> core_n_rst low from the cycle after A5 until reload completes; new words overwrite from addr0.
